// File: rtl/rs_gf1024_pkg.sv
// GF(2^10) field definitions and elaboration-time helpers for the RS syndrome bank.
// The multiply also synthesizes to a constant XOR network when one operand is a parameter.
package rs_gf1024_pkg;

  localparam int              GF_W     = 10;
  localparam logic [GF_W:0]   GF_POLY  = 11'h409;  // x^10 + x^3 + 1
  localparam logic [GF_W-1:0] GF_ALPHA = 10'd2;

  typedef logic [GF_W-1:0] gf_t;

  function automatic gf_t gf_mul(gf_t a, gf_t b);
    gf_t p;
    gf_t x;
    p = '0;
    x = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) p ^= x;
      x = {x[GF_W-2:0], 1'b0} ^ (x[GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
    end
    return p;
  endfunction

  // Square-and-multiply keeps constant evaluation short even for large exponents.
  function automatic gf_t gf_pow(gf_t a, int e);
    gf_t r;
    gf_t base;
    int  k;
    r    = 10'd1;
    base = a;
    k    = e % 1023;
    while (k > 0) begin
      if ((k & 1) != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
      k    = k >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_syn_lane.sv
// One syndrome: constant-weighted XOR of a beat plus Horner feedback of the accumulator.
// Next-state value is exported so the bank can capture a closing frame without a cycle of delay.
module rs_syn_lane
  import rs_gf1024_pkg::*;
#(
  parameter int M        = 32,
  parameter int ROOT_EXP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   first,
  input  logic [M-1:0][GF_W-1:0] data,
  output gf_t                    acc_nxt
);

  function automatic logic [M-1:0][GF_W-1:0] gen_wgt();
    logic [M-1:0][GF_W-1:0] w;
    for (int m = 0; m < M; m++) w[m] = gf_pow(GF_ALPHA, ROOT_EXP * (M - 1 - m));
    return w;
  endfunction

  localparam logic [M-1:0][GF_W-1:0] WGT = gen_wgt();
  localparam gf_t                    FB  = gf_pow(GF_ALPHA, ROOT_EXP * M);

  gf_t acc_q;
  gf_t beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int m = 0; m < M; m++) beat_sum ^= gf_mul(data[m], WGT[m]);
    acc_nxt = (first ? '0 : gf_mul(acc_q, FB)) ^ beat_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc_q <= '0;
    else if (en) acc_q <= acc_nxt;
  end

endmodule

// File: rtl/rs_syndrome_bank.sv
// Parallel RS syndrome generator with frame-length check, zero detect and a one-entry result buffer.
// Result appears the cycle after the closing beat; only a closing beat stalls while a result is held.
module rs_syndrome_bank
  import rs_gf1024_pkg::*;
#(
  parameter int N          = 544,
  parameter int NSYN       = 22,
  parameter int M          = 32,
  parameter int FIRST_ROOT = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      start_i,
  input  logic                      last_i,
  input  logic [M-1:0][GF_W-1:0]    data_i,
  output logic                      syn_valid_o,
  input  logic                      syn_ready_i,
  output logic [NSYN-1:0][GF_W-1:0] syn_o,
  output logic                      zero_o,
  output logic                      len_err_o
);

  localparam int            BEATS    = N / M;
  localparam int            CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if (N % M != 0) begin : g_bad_len
    $error("rs_syndrome_bank: N must be a multiple of M");
  end

  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_eff;
  logic                      first;
  logic                      closing;
  logic                      accept;
  logic [NSYN-1:0][GF_W-1:0] syn_nxt;

  // A start mid-frame discards the partial frame and counts as beat 0.
  assign cnt_eff = start_i ? '0 : cnt_q;
  assign first   = start_i || (cnt_q == '0);
  assign closing = last_i || (cnt_eff == LAST_CNT);
  assign ready_o = !(syn_valid_o && !syn_ready_i && closing);
  assign accept  = valid_i && ready_o;

  for (genvar j = 0; j < NSYN; j++) begin : g_lane
    rs_syn_lane #(
      .M        (M),
      .ROOT_EXP (FIRST_ROOT + j)
    ) u_lane (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .en      (accept),
      .first   (first),
      .data    (data_i),
      .acc_nxt (syn_nxt[j])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     cnt_q <= '0;
    else if (accept) cnt_q <= closing ? '0 : cnt_eff + CW'(1);
  end

  // Loading on close takes priority, so a same-cycle drain keeps syn_valid_o high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      syn_valid_o <= 1'b0;
      syn_o       <= '0;
      zero_o      <= 1'b0;
      len_err_o   <= 1'b0;
    end else if (accept && closing) begin
      syn_valid_o <= 1'b1;
      syn_o       <= syn_nxt;
      zero_o      <= ~|syn_nxt;
      len_err_o   <= !(last_i && (cnt_eff == LAST_CNT));
    end else if (syn_valid_o && syn_ready_i) begin
      syn_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_bank.sv
// Directed bench for rs_syndrome_bank: default RS(544,522) instance plus an M=16, FIRST_ROOT=0 instance.
module tb_rs_syndrome_bank;

  logic clk;
  logic rst_n;

  // Default configuration: N=544, NSYN=22, M=32, FIRST_ROOT=1 (17 beats).
  logic              valid, ready, start, last, syn_valid, syn_ready, zero, len_err;
  logic [31:0][9:0]  data;
  logic [21:0][9:0]  syn;

  // Alternate configuration: M=16, FIRST_ROOT=0 (34 beats).
  logic              valid_b, ready_b, start_b, last_b, syn_valid_b, syn_ready_b, zero_b, len_err_b;
  logic [15:0][9:0]  data_b;
  logic [21:0][9:0]  syn_b;

  int errors = 0;
  int checks = 0;
  int not_rdy;
  int vld_seen;

  int exp_t [0:1022];
  int log_t [0:1023];

  rs_syndrome_bank #(.N(544), .NSYN(22), .M(32), .FIRST_ROOT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
    .start_i(start), .last_i(last), .data_i(data),
    .syn_valid_o(syn_valid), .syn_ready_i(syn_ready), .syn_o(syn),
    .zero_o(zero), .len_err_o(len_err)
  );

  rs_syndrome_bank #(.N(544), .NSYN(22), .M(16), .FIRST_ROOT(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_b), .ready_o(ready_b),
    .start_i(start_b), .last_i(last_b), .data_i(data_b),
    .syn_valid_o(syn_valid_b), .syn_ready_i(syn_ready_b), .syn_o(syn_b),
    .zero_o(zero_b), .len_err_o(len_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [219:0] obs, input logic [219:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  // e * alpha^p via log/antilog tables.
  function automatic logic [9:0] mulpow(logic [9:0] e, int p);
    if (e == 10'd0) return 10'd0;
    return 10'(exp_t[(log_t[e] + (p % 1023)) % 1023]);
  endfunction

  // Single error e at degree d: S_j = e * alpha^((b+j)*d).
  function automatic logic [21:0][9:0] want_syn(int b, logic [9:0] e, int d);
    logic [21:0][9:0] v;
    for (int j = 0; j < 22; j++) v[j] = mulpow(e, (b + j) * d);
    return v;
  endfunction

  // Presents one beat at the falling edge and returns just after it is accepted; valid stays high.
  task automatic send_a(input bit s, input bit l, input int lane, input logic [9:0] v);
    int guard;
    @(negedge clk);
    valid = 1'b1; start = s; last = l; data = '0;
    if (lane >= 0) data[lane] = v;
    #1;
    if (!ready) not_rdy++;
    if (syn_valid) vld_seen++;
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (!ready) chkb("beat_accept_timeout", ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    valid = 1'b0; start = 1'b0; last = 1'b0; data = '0;
    #1;
  endtask

  initial begin
    int x;
    x = 1;
    for (int i = 0; i < 1023; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 'h400) != 0) x = x ^ 'h409;
    end
    log_t[0] = 0;

    rst_n = 1'b0;
    valid = 0; start = 0; last = 0; data = '0; syn_ready = 1'b1;
    valid_b = 0; start_b = 0; last_b = 0; data_b = '0; syn_ready_b = 1'b1;
    not_rdy = 0; vld_seen = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chkb("rst_syn_valid", syn_valid, 1'b0);
    chk ("rst_syn", syn, '0);
    chkb("rst_zero", zero, 1'b0);
    chkb("rst_len_err", len_err, 1'b0);
    chkb("rst_ready", ready, 1'b1);

    // All-zero codeword.
    for (int k = 0; k < 17; k++) send_a(k == 0, k == 16, -1, 10'd0);
    end_frame();
    chkb("zero_cw_valid", syn_valid, 1'b1);
    chk ("zero_cw_syn", syn, '0);
    chkb("zero_cw_zero", zero, 1'b1);
    chkb("zero_cw_len_err", len_err, 1'b0);
    @(negedge clk); #1;
    chkb("zero_cw_drained", syn_valid, 1'b0);

    // Error 1 at degree 0: every syndrome is 1.
    for (int k = 0; k < 17; k++) send_a(k == 0, k == 16, (k == 16) ? 31 : -1, 10'd1);
    end_frame();
    chkb("deg0_valid", syn_valid, 1'b1);
    chk ("deg0_syn", syn, want_syn(1, 10'd1, 0));
    chkb("deg0_zero", zero, 1'b0);

    // Error 0x2A5 at degree 300: index 243 -> beat 7, lane 19.
    for (int k = 0; k < 17; k++) send_a(k == 0, k == 16, (k == 7) ? 19 : -1, 10'h2A5);
    end_frame();
    chk ("deg300_syn", syn, want_syn(1, 10'h2A5, 300));
    chkb("deg300_len_err", len_err, 1'b0);

    // Back-to-back frames with the result held: only frame 2's closing beat may stall.
    @(negedge clk);
    syn_ready = 1'b0; not_rdy = 0;
    for (int k = 0; k < 17; k++) send_a(k == 0, k == 16, (k == 16) ? 31 : -1, 10'd1);
    for (int k = 0; k < 16; k++) send_a(k == 0, 1'b0, (k == 7) ? 19 : -1, 10'h2A5);
    @(negedge clk);
    valid = 1'b1; start = 1'b0; last = 1'b1; data = '0;
    #1;
    chkb("stall_closing_beat", ready, 1'b0);
    repeat (4) begin @(negedge clk); #1; end
    chkb("hold_first_valid", syn_valid, 1'b1);
    chk ("hold_first_syn", syn, want_syn(1, 10'd1, 0));
    syn_ready = 1'b1;
    #1;
    chkb("stall_release", ready, 1'b1);
    @(posedge clk);
    end_frame();
    chkb("second_valid", syn_valid, 1'b1);
    chk ("second_syn", syn, want_syn(1, 10'h2A5, 300));
    @(negedge clk); #1;
    chkb("second_drained", syn_valid, 1'b0);
    chk ("no_early_stall", 220'(not_rdy), 220'(0));

    // Short frame: last on beat 5.
    for (int k = 0; k < 6; k++) send_a(k == 0, k == 5, -1, 10'd0);
    end_frame();
    chkb("short_valid", syn_valid, 1'b1);
    chkb("short_len_err", len_err, 1'b1);

    // Restart at beat 8 drops the partial frame.
    @(negedge clk);
    vld_seen = 0;
    for (int k = 0; k < 8; k++) send_a(k == 0, 1'b0, (k == 2) ? 0 : -1, 10'h3FF);
    for (int k = 0; k < 17; k++) send_a(k == 0, k == 16, (k == 16) ? 31 : -1, 10'd1);
    end_frame();
    chk ("restart_single_result", 220'(vld_seen), 220'(0));
    chkb("restart_valid", syn_valid, 1'b1);
    chk ("restart_syn", syn, want_syn(1, 10'd1, 0));
    chkb("restart_len_err", len_err, 1'b0);

    // Reset at beat 9, then a clean frame.
    @(negedge clk);
    for (int k = 0; k < 9; k++) send_a(k == 0, 1'b0, (k == 3) ? 5 : -1, 10'h155);
    @(negedge clk);
    valid = 1'b0; rst_n = 1'b0;
    #1;
    chkb("mid_rst_valid", syn_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) send_a(k == 0, k == 16, (k == 7) ? 19 : -1, 10'h2A5);
    end_frame();
    chkb("post_rst_valid", syn_valid, 1'b1);
    chk ("post_rst_syn", syn, want_syn(1, 10'h2A5, 300));
    chkb("post_rst_len_err", len_err, 1'b0);

    // M=16, FIRST_ROOT=0: degree 300 -> index 243 -> beat 15, lane 3.
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      valid_b = 1'b1; start_b = (k == 0); last_b = (k == 33); data_b = '0;
      if (k == 15) data_b[3] = 10'h2A5;
      @(posedge clk);
    end
    @(negedge clk);
    valid_b = 1'b0; start_b = 1'b0; last_b = 1'b0; data_b = '0;
    #1;
    chkb("m16_valid", syn_valid_b, 1'b1);
    chk ("m16_syn", syn_b, want_syn(0, 10'h2A5, 300));
    chkb("m16_len_err", len_err_b, 1'b0);
    chkb("m16_zero", zero_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_bank.md
# rs_syndrome_bank

Parametrised syndrome generator for the RS decoder front end. It computes all NSYN syndromes of one received codeword in parallel from an M-symbol-per-beat stream, checks frame length, and flags error-free codewords. It adds a valid/ready output buffer so the next frame can overlap with the downstream key-equation solver consuming the previous result. It sits between the receive framer and the Berlekamp–Massey stage; the default configuration is RS(544,522) over GF(2^10).

## Interface
- N, 544: codeword length in symbols; N % M == 0 required (elaboration-time assertion).
- NSYN, 22: number of syndromes (2T).
- M, 32: symbols per input beat.
- FIRST_ROOT, 1: exponent b of the first root; syndrome j (0..NSYN-1) uses root α^(b+j).
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i && ready_o.
- start_i  in  1  marks the first beat of a frame.
- last_i  in  1  marks the final beat of a frame.
- data_i  in  M×10  beat symbols; lane 0 carries the highest-degree symbol of the beat.
- syn_valid_o  out  1  result buffer holds a frame result.
- syn_ready_i  in  1  downstream accepts the result.
- syn_o  out  NSYN×10  syndromes; element j = S_(b+j).
- zero_o  out  1  all syndromes are zero (codeword error-free).
- len_err_o  out  1  frame length was not N/M beats.

## Operation
- BEATS = N/M. Beat k (k = 0 first) lane m carries the coefficient of degree N-1-(k·M+m).
- Each accepted beat updates the per-syndrome accumulator: acc_j ← (first ? 0 : acc_j·α^((b+j)M)) ⊕ Σ_m data_i[m]·α^((b+j)(M-1-m)). All products are constant GF(2^10) multiplies.
- The beat counter cnt runs 0..BEATS-1. A beat is "first" when cnt == 0 or start_i == 1.
- start_i with cnt ≠ 0: the partial frame is silently discarded. The beat restarts accumulation as beat 0, and cnt becomes 1.
- A frame closes on an accepted beat with last_i = 1, or at cnt == BEATS-1. On close:
  - the next-state accumulators load the result buffer;
  - len_err = !(last_i && cnt == BEATS-1), where cnt here includes a restart by start_i;
  - zero = OR-reduction of all next-state syndromes == 0;
  - cnt resets to 0.
- A beat at cnt == BEATS-1 without last_i still closes the frame with len_err = 1. Later beats start a new frame.
- Result buffer (one entry): set on close; cleared on syn_valid_o && syn_ready_i. Close and drain in the same cycle: the new result loads and syn_valid_o stays 1.
- ready_o = !(syn_valid_o && !syn_ready_i && closing_beat), where closing_beat = last_i || cnt == BEATS-1. Only the closing beat stalls; earlier beats of the next frame are always accepted.
- ready_o depends combinationally on syn_ready_i, valid-independent inputs, and cnt. There is no combinational path from valid_i.
- valid_i = 0 holds all state.

## Timing
- Reset values: syn_valid_o = 0, syn_o = 0, zero_o = 0, len_err_o = 0, cnt = 0, accumulators = 0. ready_o = 1 after reset.
- Latency: the result is visible on syn_o, zero_o and len_err_o with syn_valid_o = 1 in the cycle after the closing beat is accepted.
- Throughput: one beat per cycle. Back-to-back frames run at full rate when syn_ready_i is held high.
- syn_o, zero_o and len_err_o are stable while syn_valid_o && !syn_ready_i.
- Reset mid-frame or mid-hold: all state is cleared immediately and the pending result is lost.
- Combinational depth per cycle: one constant multiply, an M+1-input XOR tree, and the feedback multiply. There is no internal pipelining.

## Structure
- Package rs_gf1024_pkg holds:
  - field constants: primitive polynomial x^10+x^3+1 and element width 10;
  - functions gf_mul and gf_pow for elaboration-time constant generation;
  - a typedef for a GF(2^10) symbol.
  - All weights and feedback constants are computed in the bank from parameters. There are no hard-coded tables.
- Sub-module rs_syn_lane (parameter ROOT_EXP) holds:
  - one syndrome's weight multipliers, XOR reduction and accumulator register;
  - it is instantiated NSYN times in a generate loop.
- The top level owns cnt, the close/len_err logic, the zero-detect, the result buffer and ready_o.

## Test plan
- All-zero codeword, 17 beats, syn_ready_i = 1 → one result, syn_o all 0, zero_o = 1, len_err_o = 0, one cycle after the last beat.
- Single error value 1 at degree 0 (beat 16, lane 31) → every S_j = 1, zero_o = 0.
- Error value e = 10'h2A5 at degree d = 300 → S_j = e·α^((1+j)·300) for j = 0..21, matching a software model. Repeat the check with M = 16 and with FIRST_ROOT = 0.
- Two back-to-back frames with syn_ready_i = 0 until 5 cycles after the second frame's beat 15 → ready_o = 0 only on beat 16 of frame 2. Both results arrive in order without loss.
- Frame with last_i on beat 5 → len_err_o = 1. Second frame with start_i at beat 8 of the first → first frame dropped, one result, len_err_o = 0.
- rst_ni asserted at beat 9, then a clean frame → no stale result, and the result matches the clean frame alone.
